// File: rtl/contador_pkg.sv
// Shared types and constants for the contador_modo counter.
// State encoding is fixed because it is visible to other lab designs.
package contador_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StSat  = 2'b10
    } state_t;

    localparam logic DirUp    = 1'b1;
    localparam logic DirDown  = 1'b0;
    localparam logic ModeWrap = 1'b1;
    localparam logic ModeSat  = 1'b0;

endpackage

// File: rtl/contador_next.sv
// Combinational next-count calculator for contador_modo.
// Produces the stepped value plus wrap/saturate event flags.
module contador_next
    import contador_pkg::*;
#(
    parameter int unsigned WIDTH = 3
) (
    input  logic [WIDTH-1:0] count,
    input  logic [WIDTH-1:0] max_number,
    input  logic             up_down,
    input  logic             wrap_mode,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_event,
    output logic             sat_event
);

    logic at_top;
    logic at_bottom;

    // count >= max_number also covers a bound lowered below the current count
    assign at_top    = (count >= max_number);
    assign at_bottom = (count == '0);

    always_comb begin
        next_count = count;
        wrap_event = 1'b0;
        sat_event  = 1'b0;
        if (up_down == DirUp) begin
            if (!at_top) begin
                // count < max_number <= 2^WIDTH-1, so the increment cannot overflow
                next_count = count + 1'b1;
            end else if (wrap_mode == ModeWrap) begin
                next_count = '0;
                wrap_event = 1'b1;
            end else begin
                next_count = max_number;
                sat_event  = 1'b1;
            end
        end else begin
            if (!at_bottom) begin
                next_count = count - 1'b1;
            end else if (wrap_mode == ModeWrap) begin
                next_count = max_number;
                wrap_event = 1'b1;
            end else begin
                next_count = '0;
                sat_event  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/contador_modo.sv
// WIDTH-bit bounded up/down counter with wrap/saturate modes, load and enable.
// Holds the control FSM and all registered outputs.
module contador_modo
    import contador_pkg::*;
#(
    parameter int unsigned      WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    input  logic             wrap_mode,
    input  logic [WIDTH-1:0] max_number,
    output logic [WIDTH-1:0] count,
    output logic             bigger_than_max,
    output logic             terminal,
    output logic             overflow,
    output logic             saturated
);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic             terminal_q;
    logic             overflow_q;
    logic             saturated_q;

    logic [WIDTH-1:0] next_count;
    logic             wrap_event;
    logic             sat_event;

    contador_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count_q),
        .max_number (max_number),
        .up_down    (up_down),
        .wrap_mode  (wrap_mode),
        .next_count (next_count),
        .wrap_event (wrap_event),
        .sat_event  (sat_event)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= RESET_VALUE;
            terminal_q  <= 1'b0;
            overflow_q  <= 1'b0;
            saturated_q <= 1'b0;
        end else if (load) begin
            state_q     <= StRun;
            count_q     <= load_value;
            terminal_q  <= 1'b0;
            overflow_q  <= 1'b0;
            saturated_q <= 1'b0;
        end else if (enable) begin
            count_q    <= next_count;
            terminal_q <= wrap_event;
            overflow_q <= overflow_q | wrap_event;
            unique case (state_q)
                // IDLE takes the enabled step on the same edge it leaves
                StIdle, StRun: begin
                    state_q     <= sat_event ? StSat : StRun;
                    saturated_q <= sat_event;
                end
                // Reversing direction or switching to wrap mode clears sat_event
                StSat: begin
                    state_q     <= sat_event ? StSat : StRun;
                    saturated_q <= sat_event;
                end
                default: begin
                    state_q     <= StIdle;
                    saturated_q <= 1'b0;
                end
            endcase
        end else begin
            terminal_q <= 1'b0;
        end
    end

    assign count           = count_q;
    assign bigger_than_max = (count_q > max_number);
    assign terminal        = terminal_q;
    assign overflow        = overflow_q;
    assign saturated       = saturated_q;

endmodule
